fft_input_buffer: RTL

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_input_buffer_if.sv | 26 ++
 rtl/fft_sample_ram.sv | 37 +++
 rtl/fft_input_buffer.sv | 103 ++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 16-point FFT input buffer.
package fft_pkg;

  localparam int DW     = 17;
  localparam int NPT    = 16;
  localparam int CPLX_W = 2 * DW;
  localparam int BUS_W  = 8 * DW;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_ISSUE = 1'b1
  } fft_state_t;

  // First-stage radix-4 rotation index for group k.
  function automatic logic [2:0] rot_idx(input logic [1:0] k);
    return {1'b0, k};
  endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// Serial sample input and butterfly-group output handshakes of the FFT input buffer.
interface fft_input_buffer_if #(
  parameter int DW = 17
);

  logic              din_valid;
  logic [DW-1:0]     din_re;
  logic [DW-1:0]     din_im;
  logic              din_ready;
  logic [8*DW-1:0]   calc_data;
  logic [2:0]        rotation;
  logic              calc_valid;
  logic              calc_ready;
  logic              calc_last;

  modport slave (
    input  din_valid, din_re, din_im, calc_ready,
    output din_ready, calc_data, rotation, calc_valid, calc_last
  );

  modport master (
    output din_valid, din_re, din_im, calc_ready,
    input  din_ready, calc_data, rotation, calc_valid, calc_last
  );

endinterface

// File: rtl/fft_sample_ram.sv
// 16-entry complex sample store: one write port, four read ports at k, k+4, k+8, k+12.
module fft_sample_ram
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [3:0]      i_waddr,
  input  logic [2*DW-1:0] i_wdata,
  input  logic [1:0]      i_raddr,
  output logic [2*DW-1:0] o_rd0,
  output logic [2*DW-1:0] o_rd1,
  output logic [2*DW-1:0] o_rd2,
  output logic [2*DW-1:0] o_rd3
);

  logic [2*DW-1:0] r_mem [NPT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The upper two address bits select the quarter of the frame.
  assign o_rd0 = r_mem[{2'b00, i_raddr}];
  assign o_rd1 = r_mem[{2'b01, i_raddr}];
  assign o_rd2 = r_mem[{2'b10, i_raddr}];
  assign o_rd3 = r_mem[{2'b11, i_raddr}];

endmodule

// File: rtl/fft_input_buffer.sv
// Collects 16-point complex frames and issues four radix-4 first-stage groups per frame.
//   state    | meaning
//   ST_LOAD  | accepting serial samples into the store, outputs idle
//   ST_ISSUE | presenting group rd_cnt to the butterfly, input stalled
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_input_buffer_if.slave   bus
);

  fft_state_t       r_state;
  logic [3:0]       r_wr_cnt;
  logic [1:0]       r_rd_cnt;
  logic             r_din_ready;
  logic             r_calc_valid;
  logic [8*DW-1:0]  r_calc_data;
  logic [2:0]       r_rotation;
  logic             r_calc_last;

  logic             w_we;
  logic [1:0]       w_rd_next;
  logic [2*DW-1:0]  w_rd0, w_rd1, w_rd2, w_rd3;
  logic [8*DW-1:0]  w_group;

  assign w_we      = (r_state == ST_LOAD) && bus.din_valid;
  // Output registers are loaded one group ahead, so the store is read at the next index.
  assign w_rd_next = (r_state == ST_ISSUE) ? r_rd_cnt + 2'd1 : 2'd0;
  assign w_group   = {w_rd3, w_rd2, w_rd1, w_rd0};

  fft_sample_ram #(.DW(DW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_cnt),
    .i_wdata ({bus.din_re, bus.din_im}),
    .i_raddr (w_rd_next),
    .o_rd0   (w_rd0),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2),
    .o_rd3   (w_rd3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LOAD;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_din_ready  <= 1'b1;
      r_calc_valid <= 1'b0;
      r_calc_data  <= '0;
      r_rotation   <= '0;
      r_calc_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (bus.din_valid) begin
            r_wr_cnt <= r_wr_cnt + 4'd1;
            if (r_wr_cnt == 4'd15) begin
              // x[15] is not part of group 0, so the group can be taken from the store now.
              r_state      <= ST_ISSUE;
              r_rd_cnt     <= '0;
              r_din_ready  <= 1'b0;
              r_calc_valid <= 1'b1;
              r_calc_data  <= w_group;
              r_rotation   <= rot_idx(2'd0);
              r_calc_last  <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.calc_ready) begin
            if (r_rd_cnt == 2'd3) begin
              r_state      <= ST_LOAD;
              r_rd_cnt     <= '0;
              r_din_ready  <= 1'b1;
              r_calc_valid <= 1'b0;
              r_calc_data  <= '0;
              r_rotation   <= '0;
              r_calc_last  <= 1'b0;
            end else begin
              r_rd_cnt    <= w_rd_next;
              r_calc_data <= w_group;
              r_rotation  <= rot_idx(w_rd_next);
              r_calc_last <= (w_rd_next == 2'd3);
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.din_ready  = r_din_ready;
  assign bus.calc_valid = r_calc_valid;
  assign bus.calc_data  = r_calc_data;
  assign bus.rotation   = r_rotation;
  assign bus.calc_last  = r_calc_last;

endmodule
